// File: rtl/register_file_p.sv
// Parametrised register file: two registered read ports, one write port with
// same-cycle bypass, optional hardwired r0, and a sequential bulk-clear engine.
module register_file_p #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_Register,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic [ADDR_W-1:0] Read_Register1,
    input  logic [ADDR_W-1:0] Read_Register2,
    output logic [DATA_W-1:0] Read_Data1,
    output logic [DATA_W-1:0] Read_Data2,
    input  logic              Clear,
    output logic              Busy
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clear_idx;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              write_en;
    logic              clear_last;
    logic [DATA_W-1:0] read_next1;
    logic [DATA_W-1:0] read_next2;

    assign Busy       = (state == CLEAR);
    assign clear_last = (clear_idx == ADDR_W'(DEPTH - 1));

    // A write only lands while idle and never when a clear is being launched.
    assign write_en = RegWrite && (state == IDLE) && !Clear &&
                      !(ZERO_EN && (Write_Register == '0));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Clear)      state_next = CLEAR;
            CLEAR:   if (clear_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        read_next1 = regs[Read_Register1];
        read_next2 = regs[Read_Register2];
        if (Busy || (ZERO_EN && (Read_Register1 == '0)))
            read_next1 = '0;
        else if (write_en && (Read_Register1 == Write_Register))
            read_next1 = Write_Data;
        if (Busy || (ZERO_EN && (Read_Register2 == '0)))
            read_next2 = '0;
        else if (write_en && (Read_Register2 == Write_Register))
            read_next2 = Write_Data;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            state      <= IDLE;
            clear_idx  <= '0;
            Read_Data1 <= '0;
            Read_Data2 <= '0;
        end else begin
            state      <= state_next;
            Read_Data1 <= read_next1;
            Read_Data2 <= read_next2;
            if ((state == IDLE) && Clear) begin
                clear_idx <= '0;
            end else if (state == CLEAR) begin
                regs[clear_idx] <= '0;
                clear_idx       <= clear_idx + ADDR_W'(1);
            end
            if (write_en)
                regs[Write_Register] <= Write_Data;
        end
    end

endmodule

// File: tb/tb_register_file_p.sv
// Directed self-checking bench for register_file_p; a second instance with
// ZERO_REG = 0 covers the ordinary-r0 configuration.
module tb_register_file_p;

    logic        Clock;
    logic        Reset;
    logic        RegWrite;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic [4:0]  Read_Register1;
    logic [4:0]  Read_Register2;
    logic        Clear;
    logic [31:0] Read_Data1;
    logic [31:0] Read_Data2;
    logic        Busy;
    logic [31:0] Read_Data1_nz;
    logic [31:0] Read_Data2_nz;
    logic        Busy_nz;

    int tests_run;
    int tests_failed;
    int busy_count;

    register_file_p #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .Clock(Clock), .Reset(Reset), .RegWrite(RegWrite),
        .Write_Register(Write_Register), .Write_Data(Write_Data),
        .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
        .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
        .Clear(Clear), .Busy(Busy)
    );

    register_file_p #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
        .Clock(Clock), .Reset(Reset), .RegWrite(RegWrite),
        .Write_Register(Write_Register), .Write_Data(Write_Data),
        .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
        .Read_Data1(Read_Data1_nz), .Read_Data2(Read_Data2_nz),
        .Clear(Clear), .Busy(Busy_nz)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic applyStimulus(input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] ra1,
                                 input logic [4:0] ra2, input logic clr);
        RegWrite       = we;
        Write_Register = wa;
        Write_Data     = wd;
        Read_Register1 = ra1;
        Read_Register2 = ra2;
        Clear          = clr;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        RegWrite       = 1'b0;
        Write_Register = '0;
        Write_Data     = '0;
        Read_Register1 = '0;
        Read_Register2 = '0;
        Clear          = 1'b0;
        Reset          = 1'b1;
        #3;
        checkOutput("reset_rd1", Read_Data1, 32'h0);
        checkOutput("reset_rd2", Read_Data2, 32'h0);
        checkOutput("reset_busy", {31'b0, Busy}, 32'h0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0);
            checkOutput("reset_read_p1", Read_Data1_nz, 32'h0);
            checkOutput("reset_read_p2", Read_Data2_nz, 32'h0);
        end

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0);
        checkOutput("r5_p1", Read_Data1, 32'hDEADBEEF);
        checkOutput("r5_p2", Read_Data2, 32'hDEADBEEF);

        applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd5, 5'd5, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        checkOutput("r0_zero_p1", Read_Data1, 32'h0);
        checkOutput("r0_zero_p2", Read_Data2, 32'h0);
        checkOutput("r0_plain_p1", Read_Data1_nz, 32'h12345678);

        applyStimulus(1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0);
        checkOutput("r7_old", Read_Data1, 32'h1);
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 1'b0);
        checkOutput("bypass_p1", Read_Data1, 32'hA5A5A5A5);
        checkOutput("bypass_other_p2", Read_Data2, 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0);
        checkOutput("bypass_r0_zero", Read_Data1, 32'h0);
        checkOutput("bypass_r0_plain", Read_Data1_nz, 32'hCAFEF00D);

        applyStimulus(1'b1, 5'd3, 32'h55, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd31, 32'h77, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b0);
        checkOutput("pre_clear_r3", Read_Data1, 32'h55);
        checkOutput("pre_clear_r31", Read_Data2, 32'h77);

        applyStimulus(1'b1, 5'd3, 32'h99, 5'd3, 5'd31, 1'b1);
        checkOutput("clear_busy_rise", {31'b0, Busy}, 32'h1);
        busy_count = 1;
        while (Busy && busy_count < 100) begin
            applyStimulus(1'b1, 5'd9, 32'hBAD, 5'd3, 5'd31, busy_count == 5);
            if (busy_count == 10)
                checkOutput("read_during_busy", Read_Data2, 32'h0);
            if (Busy)
                busy_count++;
        end
        checkOutput("busy_cycles", 32'(busy_count), 32'd32);

        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b0);
        checkOutput("post_clear_r3", Read_Data1, 32'h0);
        checkOutput("post_clear_r31", Read_Data2, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 1'b0);
        checkOutput("busy_write_dropped", Read_Data1, 32'h0);
        checkOutput("post_clear_r7", Read_Data2, 32'h0);

        applyStimulus(1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0);
        checkOutput("first_write_after_clear", Read_Data1, 32'h44);

        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1);
        for (int c = 0; c < 9; c++)
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0);
        checkOutput("busy_before_reset", {31'b0, Busy}, 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("reset_mid_clear_busy", {31'b0, Busy}, 32'h0);
        checkOutput("reset_mid_clear_rd", Read_Data1_nz, 32'h0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        applyStimulus(1'b1, 5'd6, 32'h11, 5'd0, 5'd0, 1'b0);
        checkOutput("busy_after_reset", {31'b0, Busy}, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd6, 5'd4, 1'b0);
        checkOutput("write_after_reset", Read_Data1, 32'h11);
        checkOutput("r4_cleared_by_reset", Read_Data2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
